// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared types and default timing constants for the key click
//               decoder (gesture states, 50 MHz default timings).
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Gesture classifier states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        GAP      = 3'd2,
        HOLD     = 3'd3,
        WAIT_REL = 3'd4
    } key_state_t;

    // Default timings at 50 MHz
    localparam int LONG_TIME_DEF   = 50_000_000;  // 1 s long press
    localparam int DOUBLE_GAP_DEF  = 15_000_000;  // 300 ms double-click window
    localparam int REPEAT_TIME_DEF = 10_000_000;  // 200 ms auto-repeat period
    localparam int CNT_W_DEF       = 26;

endpackage
`default_nettype wire

// File: rtl/key_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : key_tick_counter
// Description : Saturating up-counter with synchronous clear, count enable and
//               a terminal-count flag against a runtime-selectable terminal.
//               Stops at the terminal value, so it never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module key_tick_counter
    import key_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == term);
    assign tc   = w_tc;

    // Count register: clear has priority, hold once the terminal is reached
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_click_decoder
// Description : Classifies debounced active-low key gestures into single
//               click, double click and long press, emitting one-cycle,
//               registered, mutually exclusive pulses.
//               Optional macro KEY_REPEAT_EN: long_pulse auto-repeats every
//               REPEAT_TIME cycles while the long press is held.
// Revision    : 1.0 - initial release
// ============================================================================
module key_click_decoder
    import key_pkg::*;
#(
    parameter int LONG_TIME   = LONG_TIME_DEF,
    parameter int DOUBLE_GAP  = DOUBLE_GAP_DEF,
    parameter int REPEAT_TIME = REPEAT_TIME_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level_n,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] c_long_term = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] c_gap_term  = CNT_W'(DOUBLE_GAP - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] c_rep_term  = CNT_W'(REPEAT_TIME - 1);
`endif

    // Timings must be at least 2 and their terminal counts must fit in CNT_W
    localparam bit c_params_ok = (LONG_TIME >= 2) && (DOUBLE_GAP >= 2) &&
                                 (REPEAT_TIME >= 2) && (CNT_W >= 1) && (CNT_W <= 31) &&
                                 ((LONG_TIME - 1)   < (1 << CNT_W)) &&
                                 ((DOUBLE_GAP - 1)  < (1 << CNT_W)) &&
                                 ((REPEAT_TIME - 1) < (1 << CNT_W));

    generate
        if (!c_params_ok) begin : g_param_err
            $error("key_click_decoder: illegal timing parameters for CNT_W");
        end
    endgenerate

    key_state_t       r_state;
    key_state_t       w_state_next;
    logic             w_single_next;
    logic             w_double_next;
    logic             w_long_next;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_term;

    key_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .term  (w_term),
        .tc    (w_tc)
    );

    // Next-state, pulse and counter control; every state change clears the counter
    always_comb begin
        w_state_next  = r_state;
        w_single_next = 1'b0;
        w_double_next = 1'b0;
        w_long_next   = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_en      = 1'b0;
        w_term        = c_long_term;
        case (r_state)
            IDLE: begin
                if (!key_level_n) begin
                    w_state_next = PRESS1;
                    w_cnt_clr    = 1'b1;
                end
            end
            PRESS1: begin
                w_term = c_long_term;
                if (key_level_n) begin
                    w_state_next = GAP;
                    w_cnt_clr    = 1'b1;
                end else if (w_tc) begin
                    w_long_next  = 1'b1;
                    w_state_next = HOLD;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            GAP: begin
                // A second press beats a simultaneous timeout
                w_term = c_gap_term;
                if (!key_level_n) begin
                    w_double_next = 1'b1;
                    w_state_next  = WAIT_REL;
                    w_cnt_clr     = 1'b1;
                end else if (w_tc) begin
                    w_single_next = 1'b1;
                    w_state_next  = IDLE;
                    w_cnt_clr     = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            HOLD: begin
                if (key_level_n) begin
                    w_state_next = IDLE;
                    w_cnt_clr    = 1'b1;
                end
`ifdef KEY_REPEAT_EN
                else begin
                    w_term = c_rep_term;
                    if (w_tc) begin
                        w_long_next = 1'b1;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
`endif
            end
            WAIT_REL: begin
                // The press that made the double can never become a long press
                if (key_level_n) begin
                    w_state_next = IDLE;
                    w_cnt_clr    = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_clr    = 1'b1;
            end
        endcase
    end

    // State and registered one-cycle output pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            single_pulse <= w_single_next;
            double_pulse <= w_double_next;
            long_pulse   <= w_long_next;
        end
    end

endmodule
`default_nettype wire
